// File: rtl/interboard_tx_queue_if.sv
// Game-control push fields, sender handshake and queue status for interboard_tx_queue.
// The queue side uses the slave modport; the driving side (game control/sender) uses master.
interface interboard_tx_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          transmit;
  logic          ctrl_en;
  logic          ctrl_move_dir;
  logic [4:0]    ctrl_block_x;
  logic [2:0]    ctrl_block_y;
  logic [3:0]    ctrl_msg_type;
  logic [5:0]    ctrl_card;
  logic [2:0]    ctrl_sel_len;
  logic          send_busy;
  logic          out_en;
  logic          out_move_dir;
  logic [4:0]    out_block_x;
  logic [2:0]    out_block_y;
  logic [3:0]    out_msg_type;
  logic [5:0]    out_card;
  logic [2:0]    out_sel_len;
  logic [CW-1:0] queue_count;
  logic          queue_full;
  logic          queue_empty;
  logic          overflow;
  logic          start_timeout_err;

  modport master (
    output transmit, ctrl_en, ctrl_move_dir, ctrl_block_x, ctrl_block_y,
           ctrl_msg_type, ctrl_card, ctrl_sel_len, send_busy,
    input  out_en, out_move_dir, out_block_x, out_block_y, out_msg_type,
           out_card, out_sel_len, queue_count, queue_full, queue_empty,
           overflow, start_timeout_err
  );

  modport slave (
    input  transmit, ctrl_en, ctrl_move_dir, ctrl_block_x, ctrl_block_y,
           ctrl_msg_type, ctrl_card, ctrl_sel_len, send_busy,
    output out_en, out_move_dir, out_block_x, out_block_y, out_msg_type,
           out_card, out_sel_len, queue_count, queue_full, queue_empty,
           overflow, start_timeout_err
  );
endinterface

// File: rtl/interboard_tx_queue.sv
// Buffers game-control messages and issues them one at a time to the interboard sender.
// Issue one edge after a push lands (registered out_en); pushes while full are dropped and flagged, no backpressure.
module interboard_tx_queue #(
  parameter int DEPTH         = 4,
  parameter int START_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                interboard_rst,
  interboard_tx_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(START_TIMEOUT);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_START = 2'd1;
  localparam logic [1:0] WAIT_DONE  = 2'd2;

  logic [21:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [TW-1:0] tmo_cnt;
  logic [21:0]   out_entry;
  logic          out_en;
  logic          overflow;
  logic          start_timeout_err;

  logic          srst;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [21:0]   in_entry;

  assign srst     = rst | interboard_rst;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_entry = {bus.ctrl_move_dir, bus.ctrl_block_x, bus.ctrl_block_y,
                     bus.ctrl_msg_type, bus.ctrl_card, bus.ctrl_sel_len};

  // Full is taken from the registered count, so a same-cycle pop never makes room.
  assign push = bus.ctrl_en && !full;
  assign pop  = (state == IDLE) && !empty && bus.transmit && !bus.send_busy;

  always_ff @(posedge clk) begin
    if (!srst && push) begin
      mem[wptr] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wptr              <= '0;
      rptr              <= '0;
      count             <= '0;
      state             <= IDLE;
      tmo_cnt           <= '0;
      out_entry         <= '0;
      out_en            <= 1'b0;
      overflow          <= 1'b0;
      start_timeout_err <= 1'b0;
    end else begin
      out_en <= 1'b0;

      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (bus.ctrl_en && full) begin
        overflow <= 1'b1;
      end

      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            out_entry <= mem[rptr];
            out_en    <= 1'b1;
            rptr      <= rptr + 1'b1;
            tmo_cnt   <= '0;
            state     <= WAIT_START;
          end
        end
        WAIT_START: begin
          if (bus.send_busy) begin
            state <= WAIT_DONE;
          end else if (tmo_cnt == TW'(START_TIMEOUT - 1)) begin
            // The sender never picked the entry up; it is dropped rather than reissued.
            start_timeout_err <= 1'b1;
            state             <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.send_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_en            = out_en;
  assign bus.out_move_dir      = out_entry[21];
  assign bus.out_block_x       = out_entry[20:16];
  assign bus.out_block_y       = out_entry[15:13];
  assign bus.out_msg_type      = out_entry[12:9];
  assign bus.out_card          = out_entry[8:3];
  assign bus.out_sel_len       = out_entry[2:0];
  assign bus.queue_count       = count;
  assign bus.queue_full        = full;
  assign bus.queue_empty       = empty;
  assign bus.overflow          = overflow;
  assign bus.start_timeout_err = start_timeout_err;
endmodule
